mat_seq_ctrl: RTL and testbench

//  Sequencer for the 512-sample matrix pipeline. Takes (a,b) pairs on a ready/valid

---
 rtl/mat_ctrl_pkg.sv | 21 ++
 rtl/mat_seq_ctrl_if.sv | 35 +++
 rtl/mat_ctrl_out_reg.sv | 31 +++
 rtl/mat_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mat_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_ctrl_pkg.sv
// Shared types and constants for the matrix pipeline sequencer.
// Holds the FSM state enum and the frame-shape defaults.
package mat_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        TERM,
        WAIT,
        RADDR,
        RWAIT,
        ROUT
    } state_e;

    localparam int N_LOAD_DEF = 512;
    localparam int N_OUT_DEF  = 32;
    localparam int CLR_CYC    = 2;
    localparam int TERM_CYC   = 2;

endpackage

// File: rtl/mat_seq_ctrl_if.sv
// Sample stream, pipeline load/read bus and result stream of the sequencer.
// slave is the sequencer's view, master is the environment's view.
interface mat_seq_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 32
) ();

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_a;
    logic [DATA_W-1:0] s_b;
    logic              p_rst;
    logic [DATA_W-1:0] p_a;
    logic [DATA_W-1:0] p_b;
    logic [IDX_W-1:0]  p_index;
    logic              p_done;
    logic [DATA_W-1:0] p_sum;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport slave (
        input  s_valid, s_a, s_b, p_done, p_sum, m_ready,
        output s_ready, p_rst, p_a, p_b, p_index,
        output m_valid, m_data, m_last
    );

    modport master (
        output s_valid, s_a, s_b, p_done, p_sum, m_ready,
        input  s_ready, p_rst, p_a, p_b, p_index,
        input  m_valid, m_data, m_last
    );

endinterface

// File: rtl/mat_ctrl_out_reg.sv
// One-entry result holding register with valid/ready output.
// Word and last flag stay stable until the consumer accepts them.
module mat_ctrl_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_last  <= load_last;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mat_seq_ctrl.sv
// Frame sequencer: loads samples into the matrix pipeline, waits for it,
// then reads the results back by index onto an output stream.
module mat_seq_ctrl
    import mat_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 32,
    parameter int N_LOAD  = N_LOAD_DEF,
    parameter int N_OUT   = N_OUT_DEF,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           err_tmo,
    mat_seq_ctrl_if.slave  bus
);

    typedef logic [IDX_W:0] cnt_t;

    localparam cnt_t LAST_BEAT = cnt_t'(N_LOAD - 1);
    localparam cnt_t LAST_K    = cnt_t'(N_OUT - 1);
    localparam cnt_t TMO_LAST  = cnt_t'(TIMEOUT - 1);
    localparam logic [7:0] CLR_LAST  = 8'(CLR_CYC - 1);
    localparam logic [7:0] TERM_LAST = 8'(TERM_CYC - 1);
    localparam logic [7:0] RD_LAST   = 8'(RD_LAT - 1);
    localparam logic [IDX_W-1:0] END_IDX = IDX_W'(N_LOAD + 1);

    state_e            state, state_n;
    cnt_t              cnt, cnt_n;
    cnt_t              k, k_n;
    cnt_t              tmo, tmo_n;
    logic [7:0]        ph, ph_n;
    logic [IDX_W-1:0]  idx_n;
    logic [DATA_W-1:0] a_n, b_n;
    logic              done_n, err_n, ld;

    assign busy        = (state != IDLE);
    assign bus.s_ready = (state == LOAD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            k           <= '0;
            tmo         <= '0;
            ph          <= '0;
            done        <= 1'b0;
            err_tmo     <= 1'b0;
            bus.p_rst   <= 1'b0;
            bus.p_a     <= '0;
            bus.p_b     <= '0;
            bus.p_index <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            k           <= k_n;
            tmo         <= tmo_n;
            ph          <= ph_n;
            done        <= done_n;
            err_tmo     <= err_n;
            bus.p_rst   <= (state_n != CLR);
            bus.p_a     <= a_n;
            bus.p_b     <= b_n;
            bus.p_index <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = k;
        tmo_n   = tmo;
        ph_n    = ph;
        idx_n   = bus.p_index;
        a_n     = bus.p_a;
        b_n     = bus.p_b;
        done_n  = 1'b0;
        err_n   = err_tmo;
        ld      = 1'b0;
        unique case (state)
            IDLE: begin
                idx_n = '0;
                if (start) begin
                    state_n = CLR;
                    err_n   = 1'b0;
                    cnt_n   = '0;
                    k_n     = '0;
                    tmo_n   = '0;
                    ph_n    = '0;
                end
            end
            CLR: begin
                if (ph == CLR_LAST) begin
                    state_n = LOAD;
                    ph_n    = '0;
                end else begin
                    ph_n = ph + 8'd1;
                end
            end
            LOAD: begin
                if (bus.s_valid) begin
                    a_n   = bus.s_a;
                    b_n   = bus.s_b;
                    idx_n = IDX_W'(cnt + 1'b1);
                    cnt_n = cnt + 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_n = TERM;
                        ph_n    = '0;
                    end
                end
            end
            TERM: begin
                idx_n = END_IDX;
                if (ph == TERM_LAST) begin
                    state_n = WAIT;
                    tmo_n   = '0;
                end else begin
                    ph_n = ph + 8'd1;
                end
            end
            WAIT: begin
                if (bus.p_done) begin
                    state_n = RADDR;
                    tmo_n   = '0;
                end else if (tmo == TMO_LAST) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                    tmo_n   = '0;
                end else begin
                    tmo_n = tmo + 1'b1;
                end
            end
            RADDR: begin
                idx_n   = IDX_W'(k);
                ph_n    = '0;
                state_n = RWAIT;
            end
            RWAIT: begin
                if (ph == RD_LAST) begin
                    ld      = 1'b1;
                    state_n = ROUT;
                end else begin
                    ph_n = ph + 8'd1;
                end
            end
            ROUT: begin
                // m_valid is always high here, so m_ready alone is the handshake
                if (bus.m_ready) begin
                    if (k == LAST_K) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        k_n     = k + 1'b1;
                        state_n = RADDR;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    mat_ctrl_out_reg #(
        .DATA_W (DATA_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (ld),
        .load_data (bus.p_sum),
        .load_last (k == LAST_K),
        .m_ready   (bus.m_ready),
        .m_valid   (bus.m_valid),
        .m_data    (bus.m_data),
        .m_last    (bus.m_last)
    );

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Directed/random bench for mat_seq_ctrl with a behavioural pipeline
// model (p_done after 100 end-of-load cycles, p_sum = 1000 + index).
module tb_mat_seq_ctrl;

    localparam int N_LOAD  = 512;
    localparam int N_OUT   = 32;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst, start, busy, done, err_tmo;
    int   errors = 0;
    int   checks = 0;
    int   wcnt = 0;
    bit   pd_en = 1'b1;
    logic [31:0] exp_pa = '0;
    logic [31:0] exp_pb = '0;

    mat_seq_ctrl_if #(.DATA_W(32), .IDX_W(32)) bus ();

    mat_seq_ctrl #(
        .DATA_W (32),
        .IDX_W  (32),
        .N_LOAD (N_LOAD),
        .N_OUT  (N_OUT),
        .RD_LAT (1),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .err_tmo(err_tmo),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // pipeline model: finishes 100 cycles after it sees the end-of-load index
    always @(posedge clk) begin
        if (!bus.p_rst)
            wcnt <= 0;
        else if (bus.p_index == 32'(N_LOAD + 1))
            wcnt <= wcnt + 1;
    end
    assign bus.p_done = pd_en && (wcnt >= 100);
    assign bus.p_sum  = 32'd1000 + bus.p_index;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1;
        check("start_busy", busy, 1);
        check("start_prst", bus.p_rst, 0);
        check("start_errclr", err_tmo, 0);
        @(negedge clk) start = 1'b0;
        @(posedge clk) #1;
        check("clr2_prst", bus.p_rst, 0);
        check("clr2_sready", bus.s_ready, 0);
        @(posedge clk) #1;
        check("load_sready", bus.s_ready, 1);
        check("load_prst", bus.p_rst, 1);
    endtask

    task automatic load(input int nbeats, input bit rnd);
        int  acc = 0;
        int  cyc = 0;
        bit  v, take;
        logic [31:0] a, b;
        while (acc < nbeats && cyc < 4 * nbeats + 20) begin
            @(negedge clk);
            cyc++;
            v = rnd ? bit'($urandom % 2) : 1'b1;
            a = rnd ? $urandom : 32'(acc);
            b = rnd ? $urandom : -32'(acc);
            bus.s_valid = v;
            bus.s_a = a;
            bus.s_b = b;
            take = v && bus.s_ready;
            @(posedge clk) #1;
            if (take) begin
                acc++;
                exp_pa = a;
                exp_pb = b;
            end
            check("p_index", bus.p_index, acc);
            check("p_a", bus.p_a, exp_pa);
            check("p_b", bus.p_b, exp_pb);
        end
        check("load_beats", acc, nbeats);
    endtask

    task automatic term_chk();
        @(posedge clk) #1;
        check("term_idx1", bus.p_index, N_LOAD + 1);
        check("term_sready", bus.s_ready, 0);
        @(posedge clk) #1;
        check("term_idx2", bus.p_index, N_LOAD + 1);
    endtask

    task automatic collect(input bit slow);
        int n = 0;
        int dn = 0;
        int extra = 0;
        int after = 0;
        int cyc = 0;
        bit pv = 0, pr = 0, rdy, pl = 0;
        logic [31:0] pd = '0;
        while (after < 4 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (done) dn++;
            if (bus.m_valid) begin
                if (pv && !pr)
                    check("m_hold", {bus.m_data, bus.m_last}, {pd, pl});
                if (n >= N_OUT) extra++;
            end
            rdy = slow ? ($urandom % 3 == 0) : 1'b1;
            bus.m_ready = rdy;
            if (bus.m_valid && rdy && n < N_OUT) begin
                check("m_data", bus.m_data, 1000 + n);
                check("m_last", bus.m_last, n == N_OUT - 1);
                n++;
            end
            pv = bus.m_valid;
            pr = rdy;
            pd = bus.m_data;
            pl = bus.m_last;
            if (n >= N_OUT) after++;
        end
        bus.m_ready = 1'b0;
        check("words", n, N_OUT);
        check("extra_words", extra, 0);
        check("done_pulses", dn, 1);
        check("busy_end", busy, 0);
    endtask

    initial begin
        int  bc, cyc;
        bit  sawv, sawd;
        rst = 1'b0;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_a = '0;
        bus.s_b = '0;
        bus.m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err_tmo, 0);
        check("rst_sready", bus.s_ready, 0);
        check("rst_mvalid", bus.m_valid, 0);
        check("rst_mlast", bus.m_last, 0);
        check("rst_prst", bus.p_rst, 0);
        check("rst_pa", bus.p_a, 0);
        check("rst_pb", bus.p_b, 0);
        check("rst_pidx", bus.p_index, 0);
        check("rst_mdata", bus.m_data, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        check("idle_prst", bus.p_rst, 1);

        // frame 1: contiguous a=i, b=-i, consumer always ready
        do_start();
        load(N_LOAD, 1'b0);
        term_chk();
        collect(1'b0);

        // frame 2: random gaps and data, slow consumer
        do_start();
        load(N_LOAD, 1'b1);
        term_chk();
        collect(1'b1);

        // frame 3: pipeline never finishes
        pd_en = 1'b0;
        do_start();
        load(N_LOAD, 1'b0);
        bc = 0;
        cyc = 0;
        sawv = 0;
        sawd = 0;
        while (busy && cyc < 6000) begin
            @(posedge clk) #1;
            cyc++;
            if (busy) bc++;
            sawv |= bus.m_valid;
            sawd |= done;
        end
        @(posedge clk) #1;
        sawd |= done;
        check("tmo_err", err_tmo, 1);
        check("tmo_idle", busy, 0);
        // one TERM cycle left after the last beat, then the full timeout
        check("tmo_cycles", bc, 1 + TIMEOUT);
        check("tmo_no_mvalid", sawv, 0);
        check("tmo_no_done", sawd, 0);
        pd_en = 1'b1;

        // frame 4: aborted by reset at beat 200
        do_start();
        load(200, 1'b1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        exp_pa = '0;
        exp_pb = '0;
        check("abort_busy", busy, 0);
        check("abort_pidx", bus.p_index, 0);
        check("abort_pa", bus.p_a, 0);
        check("abort_done", done, 0);
        check("abort_mvalid", bus.m_valid, 0);

        // frame 5: clean frame; start and s_valid in WAIT are ignored
        do_start();
        load(N_LOAD, 1'b1);
        term_chk();
        repeat (5) begin
            @(negedge clk);
            start = 1'b1;
            bus.s_valid = 1'b1;
            bus.s_a = $urandom;
            bus.s_b = $urandom;
            @(posedge clk) #1;
            check("wait_busy", busy, 1);
            check("wait_pa", bus.p_a, exp_pa);
            check("wait_pidx", bus.p_index, N_LOAD + 1);
            @(negedge clk);
            start = 1'b0;
            bus.s_valid = 1'b0;
        end
        collect(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
